// File: rtl/timer_fsm_if.sv
// Control/status bundle between the upstream controller and the countdown timer.
// The master drives clr/start/delay; the slave (the timer) returns ready/busy/count/overrun.
interface timer_fsm_if #(
  parameter int WIDTH = 8
);
  logic             clr;
  logic             start;
  logic [WIDTH-1:0] delay;
  logic             ready;
  logic             busy;
  logic [WIDTH-1:0] count;
  logic             overrun;

  modport master (
    output clr,
    output start,
    output delay,
    input  ready,
    input  busy,
    input  count,
    input  overrun
  );

  modport slave (
    input  clr,
    input  start,
    input  delay,
    output ready,
    output busy,
    output count,
    output overrun
  );
endinterface

// File: rtl/timer_fsm.sv
// Moore countdown timer: an accepted start with delay D raises ready D edges later.
// Handshake: start is a level sampled on every rising edge, no ready/valid back-pressure;
// ready/busy are pure state decodes, and a start seen while busy is dropped and flagged in overrun.
module timer_fsm #(
  parameter int WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  timer_fsm_if.slave  bus,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    COUNTING = 2'b01,
    DONE     = 2'b10
  } state_t;

  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO = '0;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_nx;
  logic             overrun_q;
  logic             overrun_nx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      count_q   <= ZERO;
      overrun_q <= 1'b0;
    end else begin
      state     <= state_nx;
      count_q   <= count_nx;
      overrun_q <= overrun_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    count_nx   = count_q;
    overrun_nx = overrun_q;
    if (bus.clr) begin
      state_nx   = IDLE;
      count_nx   = ZERO;
      overrun_nx = 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          // A zero delay skips COUNTING so ready appears after the accepting edge.
          if (bus.start) begin
            if (bus.delay != ZERO) begin
              state_nx = COUNTING;
              count_nx = bus.delay;
            end else begin
              state_nx = DONE;
              count_nx = ZERO;
            end
          end
        end
        COUNTING: begin
          if (bus.start) begin
            overrun_nx = 1'b1;
          end
          // Anything at or below one finishes, so the counter can never wrap.
          if (count_q > ONE) begin
            count_nx = count_q - ONE;
          end else begin
            state_nx = DONE;
            count_nx = ZERO;
          end
        end
        default: begin
          state_nx = IDLE;
          count_nx = ZERO;
        end
      endcase
    end
  end

  assign bus.ready   = (state == DONE);
  assign bus.busy    = (state == COUNTING);
  assign bus.count   = count_q;
  assign bus.overrun = overrun_q;
  assign state_dbg   = state;

endmodule

// File: doc/timer_fsm.md
TIMER_FSM -- requirements
Module: timer_fsm

Interface
REQ-001 Parameter WIDTH, default 8, width of the delay value and the counter.
REQ-002 CLK  input  1  the single clock; all state changes on rising edge.
REQ-003 RST  input  1  reset, asynchronous and active-high.
REQ-004 CLR  input  1  synchronous clear; driven by the upstream controller's RESET output.
REQ-005 START  input  1  start request; driven by the upstream controller's START output.
REQ-006 DELAY  input  WIDTH  delay in clock cycles; sampled only on an accepted START.
REQ-007 READY  output  1  delay elapsed; drives the upstream controller's READY input.
REQ-008 BUSY  output  1  countdown in progress.
REQ-009 COUNT  output  WIDTH  cycles remaining in the countdown.
REQ-010 OVERRUN  output  1  sticky flag; a START arrived while BUSY.

Function
REQ-011 The block SHALL implement a Moore state machine with states IDLE, COUNTING and DONE, each state having a distinct encoding.
REQ-012 Illegal state encodings SHALL return to IDLE on the next edge.
REQ-013 READY SHALL equal (state==DONE) and BUSY SHALL equal (state==COUNTING); both SHALL be decoded from state only, with no combinational path from any input.
REQ-014 CLR=1 SHALL override all other inputs: on the next edge, state=IDLE, COUNT=0 and OVERRUN=0.
REQ-015 IDLE, START=1 and DELAY>=1: next state=COUNTING, COUNT=DELAY.
REQ-016 IDLE, START=1 and DELAY=0: next state=DONE, COUNT=0.
REQ-017 IDLE, START=0: remain in IDLE with COUNT held.
REQ-018 COUNTING with COUNT>1: COUNT decrements by 1 per edge, state unchanged.
REQ-019 COUNTING with COUNT==1: next state=DONE, COUNT=0.
REQ-020 Timing: START sampled at edge k SHALL make READY visible after edge k+DELAY, for every DELAY from 0 to 2^WIDTH-1.
REQ-021 COUNTING, START=1: START is ignored (no reload), the countdown continues, and OVERRUN is set to 1 on that edge.
REQ-022 OVERRUN SHALL stay set until CLR or RST.
REQ-023 DONE, START=0: remain in DONE with READY held high.
REQ-024 DONE, START=1: retrigger with the same rules as REQ-015/REQ-016; READY falls on that edge unless DELAY=0.
REQ-025 DELAY changes after the START edge SHALL NOT affect a countdown in progress.
REQ-026 COUNT SHALL never wrap below 0.
REQ-027 DELAY=2^WIDTH-1 SHALL count the full range without overflow.
REQ-028 START held high over several cycles: the first edge is accepted and later edges follow REQ-021, or REQ-024 once in DONE.

Reset
REQ-029 RST=1 SHALL immediately, without waiting for a clock edge, force state=IDLE, COUNT=0, READY=0, BUSY=0 and OVERRUN=0.
REQ-030 RST asserted mid-COUNTING SHALL abort the countdown.
REQ-031 After RST deasserts, the first START edge SHALL be accepted normally.
REQ-032 All outputs SHALL be defined (no X) from RST assertion onward.

Verification
REQ-033 RST, then DELAY=5 with START pulsed at edge k -> BUSY=1 and COUNT=5,4,3,2,1 after edges k..k+4; READY=1, BUSY=0 and COUNT=0 after edge k+5.
REQ-034 DELAY=0 with a START pulse -> READY=1 after the same edge, BUSY never asserts.
REQ-035 DELAY=3, START pulse, then a second START at k+1 with DELAY=9 -> READY after k+3, OVERRUN=1 from k+1; then CLR=1 -> IDLE with OVERRUN=0.
REQ-036 DELAY=10, START, then async RST pulse between edges at k+4 -> all outputs 0 immediately; a fresh START with DELAY=2 -> READY after 2 edges.
REQ-037 In DONE, START and CLR high together -> IDLE, READY=0, COUNT=0.
REQ-038 WIDTH=8, DELAY=255 -> READY after exactly 255 edges, no wrap; then a DONE retrigger with DELAY=1 -> READY low for exactly 1 cycle.
